// File: rtl/ctrl_pkg.sv
// Shared types, default sizes and the stall-mask prefix helper for pipeline_ctrl.
package ctrl_pkg;

  localparam int unsigned DefStages  = 6;
  localparam int unsigned DefMcStage = 3;
  localparam int unsigned DefCntW    = 6;
  localparam int unsigned MaskW      = 32;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mc_state_e;

  // Sets every bit at or below the highest set request bit.
  function automatic logic [MaskW-1:0] prefix_mask(input logic [MaskW-1:0] req);
    logic [MaskW-1:0] m;
    m[MaskW-1] = req[MaskW-1];
    for (int i = MaskW - 2; i >= 0; i--) begin
      m[i] = m[i+1] | req[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/mc_timer.sv
// Multi-cycle operation FSM and latency counter; drives the MC stall source and handshake.
module mc_timer
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mc_start,
  input  logic [CNT_W-1:0] mc_cycles,
  input  logic             flush,
  input  logic             hold,
  output logic             mc_stall,
  output logic             mc_busy,
  output logic             mc_done
);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_start) begin
            state_d = StBusy;
            cnt_d   = (mc_cycles == '0) ? '0 : mc_cycles - CNT_W'(1);
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = hold ? StDone : StIdle;
          end
        end
        StDone: begin
          if (!hold) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Flush and reset both suppress the handshake in the current cycle.
  always_comb begin
    mc_stall = 1'b0;
    mc_busy  = 1'b0;
    mc_done  = 1'b0;
    if (!rst) begin
      mc_busy = (state_q == StBusy);
      if (!flush) begin
        mc_stall = ((state_q == StIdle) && mc_start) || ((state_q == StBusy) && (cnt_q != '0));
        mc_done  = ((state_q == StBusy) && (cnt_q == '0)) || (state_q == StDone);
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall mask, flush/redirect and multi-cycle handshake.
// Optional PIPELINE_CTRL_STATS_EN adds stall_cycles and flush_count counters.
module pipeline_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned STAGES   = DefStages,
  parameter int unsigned MC_STAGE = DefMcStage,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic              mc_done
`ifdef PIPELINE_CTRL_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  logic             mc_stall;
  logic             hold;
  logic [MaskW-1:0] src;
  logic [MaskW-1:0] full_mask;
  logic             unused_mask;

  // Any request at or above MC_STAGE holds the multi-cycle stage.
  assign hold = |stallreq[STAGES-1:MC_STAGE];

  mc_timer #(
    .CNT_W(CNT_W)
  ) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_cycles(mc_cycles),
    .flush    (flush_req),
    .hold     (hold),
    .mc_stall (mc_stall),
    .mc_busy  (mc_busy),
    .mc_done  (mc_done)
  );

  always_comb begin
    src       = MaskW'(stallreq) | (MaskW'(mc_stall) << MC_STAGE);
    full_mask = prefix_mask(src);
    stall     = (rst || flush_req) ? '0 : full_mask[STAGES-1:0];
    flush     = flush_req && !rst;
    new_pc    = flush ? flush_pc : 32'h0;
  end

  assign unused_mask = ^full_mask[MaskW-1:STAGES];

`ifdef PIPELINE_CTRL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall[0]) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush)    flush_count_q  <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected outputs, monitor checks at negedge.
module tb_pipeline_ctrl;

  typedef struct {
    logic        chk;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stallreq = '0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mc_start = 1'b0;
  logic [5:0]  mc_cycles = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
`ifdef PIPELINE_CTRL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  exp_t q[$];
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .flush_req(flush_req),
    .flush_pc (flush_pc),
    .mc_start (mc_start),
    .mc_cycles(mc_cycles),
    .stall    (stall),
    .flush    (flush),
    .new_pc   (new_pc),
    .mc_busy  (mc_busy),
    .mc_done  (mc_done)
`ifdef PIPELINE_CTRL_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] fp,
                      input logic ms, input logic [5:0] mcyc, input logic chk,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    stallreq  = sr;
    flush_req = fr;
    flush_pc  = fp;
    mc_start  = ms;
    mc_cycles = mcyc;
    e.chk   = chk;
    e.stall = es;
    e.flush = ef;
    e.pc    = ep;
    e.busy  = eb;
    e.done  = ed;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        check("stall",   32'(stall),   32'(e.stall));
        check("flush",   32'(flush),   32'(e.flush));
        check("new_pc",  new_pc,       e.pc);
        check("mc_busy", 32'(mc_busy), 32'(e.busy));
        check("mc_done", 32'(mc_done), 32'(e.done));
      end
    end
  end

  initial begin
    // rst sr fr pc ms cyc | chk stall flush pc busy done
    step(1, 6'b000010, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b000010, 0, 32'h0, 0, 0,   1, 6'b000011, 0, 32'h0, 0, 0);
    step(0, 6'b001010, 0, 32'h0, 0, 0,   1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h1234, 0, 0, 1, 6'b000000, 0, 32'h0, 0, 0);

    // mc_cycles=3
    step(0, 6'b000000, 0, 32'h0, 1, 3,   1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 1, 1);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);

    // Same op with stallreq[4] held T..T+5
    step(0, 6'b010000, 0, 32'h0, 1, 3,   1, 6'b011111, 0, 32'h0, 0, 0);
    step(0, 6'b010000, 0, 32'h0, 0, 0,   1, 6'b011111, 0, 32'h0, 1, 0);
    step(0, 6'b010000, 0, 32'h0, 0, 0,   1, 6'b011111, 0, 32'h0, 1, 0);
    step(0, 6'b010000, 0, 32'h0, 0, 0,   1, 6'b011111, 0, 32'h0, 1, 1);
    step(0, 6'b010000, 0, 32'h0, 0, 0,   1, 6'b011111, 0, 32'h0, 0, 1);
    step(0, 6'b010000, 0, 32'h0, 0, 0,   1, 6'b011111, 0, 32'h0, 0, 1);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   0, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);

    // Flush during BUSY, then a start right after is accepted
    step(0, 6'b000000, 0, 32'h0, 1, 3,      1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 1, 32'h1000, 1, 3,   1, 6'b000000, 1, 32'h1000, 1, 0);
    step(0, 6'b000000, 0, 32'h0, 1, 1,      1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,      1, 6'b000000, 0, 32'h0, 1, 1);
    step(0, 6'b000000, 0, 32'h0, 0, 0,      1, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b111111, 1, 32'hdeadbeef, 1, 2, 1, 6'b000000, 1, 32'hdeadbeef, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,      1, 6'b000000, 0, 32'h0, 0, 0);

    // mc_cycles=0 behaves as 1
    step(0, 6'b000000, 0, 32'h0, 1, 0,   1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 1, 1);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);

    // Reset mid-BUSY
    step(0, 6'b000000, 0, 32'h0, 1, 5,   1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b001111, 0, 32'h0, 1, 0);
    step(1, 6'b000100, 1, 32'h55, 1, 2,  1, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 1, 2,   1, 6'b001111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b001111, 0, 32'h0, 1, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 1, 1);

    // Three more stalled cycles and two flushes since the last reset
    step(0, 6'b000001, 0, 32'h0, 0, 0,   1, 6'b000001, 0, 32'h0, 0, 0);
    step(0, 6'b000001, 0, 32'h0, 0, 0,   1, 6'b000001, 0, 32'h0, 0, 0);
    step(0, 6'b100000, 0, 32'h0, 0, 0,   1, 6'b111111, 0, 32'h0, 0, 0);
    step(0, 6'b000000, 1, 32'h0, 0, 0,   1, 6'b000000, 1, 32'h0, 0, 0);
    step(0, 6'b000000, 1, 32'h20, 0, 0,  1, 6'b000000, 1, 32'h20, 0, 0);
    step(0, 6'b000000, 0, 32'h0, 0, 0,   1, 6'b000000, 0, 32'h0, 0, 0);

    @(negedge clk);
    #1;
`ifdef PIPELINE_CTRL_STATS_EN
    check("stall_cycles", stall_cycles, 32'd5);
    check("flush_count",  32'(flush_count), 32'd2);
`endif
    repeat (3) @(negedge clk);
    ncmp++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
